// File: rtl/axis_video_out_port.sv
// Packs show-ahead FIFO pixels into PPC-wide AXI4-Stream video beats with tuser/tlast/tkeep.
// Latency: start 1 cycle after enable (or vsync rise); beat valid 1 cycle after the completing pixel read.
// Backpressure: 2-entry output buffer; FIFO reads stop when it is full, tready never reaches rd_en combinationally.
module axis_video_out_port #(
    parameter int    DSIZE      = 24,
    parameter int    PPC        = 1,
    parameter string MODE       = "ONCE",
    parameter string FRAME_SYNC = "OFF"
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [15:0]           hactive,
    input  logic [15:0]           vactive,
    input  logic                  in_vsync,
    input  logic [DSIZE-1:0]      in_data,
    input  logic                  fifo_empty,
    output logic                  rd_en,
    output logic [DSIZE*PPC-1:0]  axi_tdata,
    output logic [PPC-1:0]        axi_tkeep,
    output logic                  axi_tvalid,
    output logic                  axi_tuser,
    output logic                  axi_tlast,
    input  logic                  axi_tready,
    output logic                  falign,
    output logic                  lalign,
    output logic                  ealign,
    output logic                  sync_err
);

    localparam int TW        = DSIZE * PPC;
    localparam int SW        = (PPC > 1) ? $clog2(PPC) : 1;
    localparam bit LINE_MODE = (MODE == "LINE");
    localparam bit SYNC_ON   = (FRAME_SYNC == "ON");

    typedef enum logic [1:0] {IDLE, RUN, LWAIT, DRAIN} state_t;

    typedef struct packed {
        logic [TW-1:0]  dat;
        logic [PPC-1:0] keep;
        logic           user;
        logic           last;
    } beat_t;

    state_t         state;
    logic           vs_q;
    logic           vs_rise;
    logic           start;
    logic [15:0]    hsize;
    logic [15:0]    vsize;
    logic [15:0]    pcnt;
    logic [15:0]    lcnt;
    logic [SW-1:0]  sidx;
    logic [TW-1:0]  pack_dat;
    logic [PPC-1:0] pack_keep;
    logic           first_beat;
    logic           eol;
    logic           beat_done;
    logic           pop;
    logic           final_pop;
    beat_t          beat_in;
    beat_t          obuf [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     obuf_cnt;

    assign vs_rise = in_vsync & ~vs_q;
    assign start   = enable & (hactive != 16'd0) & (vactive != 16'd0) & (~SYNC_ON | vs_rise);

    assign axi_tvalid = (obuf_cnt != 2'd0);
    assign axi_tdata  = obuf[rd_ptr].dat;
    assign axi_tkeep  = obuf[rd_ptr].keep;
    assign axi_tuser  = obuf[rd_ptr].user;
    assign axi_tlast  = obuf[rd_ptr].last;

    // Read gating, beat completion and the beat as it would look with the current pixel merged in
    always_comb begin
        rd_en     = (state == RUN) & ~fifo_empty & (obuf_cnt < 2'd2);
        eol       = (pcnt == hsize - 16'd1);
        beat_done = rd_en & (eol | (int'(sidx) == PPC - 1));
        pop       = axi_tvalid & axi_tready;
        // Only the final tlast beat can be alone in the buffer once reads have stopped
        final_pop = pop & axi_tlast & (obuf_cnt == 2'd1);
        beat_in.dat  = pack_dat;
        beat_in.keep = pack_keep;
        beat_in.user = first_beat;
        beat_in.last = eol;
        for (int k = 0; k < PPC; k++) begin
            if (int'(sidx) == k) begin
                beat_in.dat[k*DSIZE +: DSIZE] = in_data;
                beat_in.keep[k]               = 1'b1;
            end
        end
    end

    // Frame/line sequencing, pixel packing and the alignment pulses
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            vs_q       <= 1'b0;
            hsize      <= '0;
            vsize      <= '0;
            pcnt       <= '0;
            lcnt       <= '0;
            sidx       <= '0;
            pack_dat   <= '0;
            pack_keep  <= '0;
            first_beat <= 1'b0;
            falign     <= 1'b0;
            lalign     <= 1'b0;
            ealign     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            falign   <= 1'b0;
            lalign   <= 1'b0;
            ealign   <= 1'b0;
            sync_err <= 1'b0;
            vs_q     <= in_vsync;
            if (SYNC_ON && vs_rise && state != IDLE) begin
                sync_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        hsize      <= hactive;
                        vsize      <= vactive;
                        pcnt       <= '0;
                        lcnt       <= '0;
                        sidx       <= '0;
                        pack_dat   <= '0;
                        pack_keep  <= '0;
                        first_beat <= 1'b1;
                        falign     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        if (beat_done) begin
                            // Cleared packer makes unfilled slots of a short final beat read as zero
                            pack_dat   <= '0;
                            pack_keep  <= '0;
                            sidx       <= '0;
                            first_beat <= 1'b0;
                        end else begin
                            pack_dat  <= beat_in.dat;
                            pack_keep <= beat_in.keep;
                            sidx      <= sidx + 1'b1;
                        end
                        if (eol) begin
                            pcnt <= '0;
                            lcnt <= lcnt + 16'd1;
                            if (lcnt == vsize - 16'd1) begin
                                state <= DRAIN;
                            end else if (LINE_MODE) begin
                                state <= LWAIT;
                            end
                        end else begin
                            pcnt <= pcnt + 16'd1;
                        end
                    end
                end
                LWAIT: begin
                    if (final_pop) begin
                        lalign <= 1'b1;
                        state  <= RUN;
                    end
                end
                DRAIN: begin
                    if (final_pop) begin
                        ealign <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry output buffer; simultaneous push and pop keeps the occupancy unchanged
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            obuf[0]  <= '0;
            obuf[1]  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            obuf_cnt <= 2'd0;
        end else begin
            if (beat_done) begin
                obuf[wr_ptr] <= beat_in;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({beat_done, pop})
                2'b10:   obuf_cnt <= obuf_cnt + 2'd1;
                2'b01:   obuf_cnt <= obuf_cnt - 2'd1;
                default: obuf_cnt <= obuf_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_video_out_port.sv
// Bench for axis_video_out_port: instance A (PPC=1, ONCE, free-running start),
// instance B (PPC=2, LINE, vsync-aligned start). Both share a show-ahead FIFO model
// whose head pixel is 1 at the start of each test and increments on every read.
`timescale 1ns/1ps
module tb_axis_video_out_port;
    localparam int DSIZE = 24;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn;
    logic [15:0] hactive, vactive;
    logic        in_vsync, fifo_empty, axi_tready;
    logic        en_a, en_b;
    logic [DSIZE-1:0] in_data;

    logic        rd_en_a, tvalid_a, tuser_a, tlast_a, falign_a, lalign_a, ealign_a, sync_err_a;
    logic [23:0] tdata_a;
    logic [0:0]  tkeep_a;
    logic        rd_en_b, tvalid_b, tuser_b, tlast_b, falign_b, lalign_b, ealign_b, sync_err_b;
    logic [47:0] tdata_b;
    logic [1:0]  tkeep_b;

    axis_video_out_port #(.DSIZE(DSIZE), .PPC(1), .MODE("ONCE"), .FRAME_SYNC("OFF")) u_a (
        .aclk(aclk), .aresetn(aresetn), .enable(en_a), .hactive(hactive), .vactive(vactive),
        .in_vsync(in_vsync), .in_data(in_data), .fifo_empty(fifo_empty), .rd_en(rd_en_a),
        .axi_tdata(tdata_a), .axi_tkeep(tkeep_a), .axi_tvalid(tvalid_a), .axi_tuser(tuser_a),
        .axi_tlast(tlast_a), .axi_tready(axi_tready), .falign(falign_a), .lalign(lalign_a),
        .ealign(ealign_a), .sync_err(sync_err_a));

    axis_video_out_port #(.DSIZE(DSIZE), .PPC(2), .MODE("LINE"), .FRAME_SYNC("ON")) u_b (
        .aclk(aclk), .aresetn(aresetn), .enable(en_b), .hactive(hactive), .vactive(vactive),
        .in_vsync(in_vsync), .in_data(in_data), .fifo_empty(fifo_empty), .rd_en(rd_en_b),
        .axi_tdata(tdata_b), .axi_tkeep(tkeep_b), .axi_tvalid(tvalid_b), .axi_tuser(tuser_b),
        .axi_tlast(tlast_b), .axi_tready(axi_tready), .falign(falign_b), .lalign(lalign_b),
        .ealign(ealign_b), .sync_err(sync_err_b));

    // Show-ahead FIFO model and cycle counter
    int rd_total = 0;
    int rd_mark  = 0;
    int cyc      = 0;
    assign in_data = DSIZE'(rd_total - rd_mark + 1);
    always @(posedge aclk) begin
        if (rd_en_a | rd_en_b) rd_total <= rd_total + 1;
        cyc <= cyc + 1;
    end

    typedef struct {
        logic [47:0] dat;
        logic [1:0]  keep;
        logic        user;
        logic        last;
    } cap_t;
    cap_t qa[$];
    cap_t qb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cur_hact = 1;

    // Monitor A: captures beats, counts pulses, checks stall stability and buffer occupancy
    int   rd_a = 0, fal_a = 0, lal_a = 0, eal_a = 0, se_a = 0;
    int   fal_cyc_a = 0, eal_cyc_a = 0, hs_cyc_a = 0, occ_a = 0;
    int   occ_viol = 0, stall_viol = 0;
    logic stall_a = 1'b0;
    cap_t stall_beat;
    always @(negedge aclk) begin
        if (!aresetn) begin
            occ_a   = 0;
            stall_a = 1'b0;
        end else begin
            if (stall_a && !(tvalid_a && tdata_a == stall_beat.dat[23:0] &&
                             tuser_a == stall_beat.user && tlast_a == stall_beat.last))
                stall_viol++;
            stall_a         = tvalid_a && !axi_tready;
            stall_beat.dat  = 48'(tdata_a);
            stall_beat.keep = 2'(tkeep_a);
            stall_beat.user = tuser_a;
            stall_beat.last = tlast_a;
            if (rd_en_a) begin
                if (occ_a >= 2) occ_viol++;
                rd_a++;
            end
            if (tvalid_a && axi_tready) begin
                qa.push_back('{48'(tdata_a), 2'(tkeep_a), tuser_a, tlast_a});
                hs_cyc_a = cyc;
            end
            occ_a = occ_a + (rd_en_a ? 1 : 0) - ((tvalid_a && axi_tready) ? 1 : 0);
            if (falign_a)   begin fal_a++; fal_cyc_a = cyc; end
            if (lalign_a)   lal_a++;
            if (ealign_a)   begin eal_a++; eal_cyc_a = cyc; end
            if (sync_err_a) se_a++;
        end
    end

    // Monitor B: captures beats, counts pulses, checks reads stay off while a line drains
    int   rd_b = 0, fal_b = 0, lal_b = 0, eal_b = 0, se_b = 0, tl_hs_b = 0;
    int   fal_cyc_b = 0, eal_cyc_b = 0, hs_cyc_b = 0, lr_b = 0, line_viol = 0;
    logic wait_b = 1'b0;
    always @(negedge aclk) begin
        if (!aresetn) begin
            lr_b   = 0;
            wait_b = 1'b0;
        end else begin
            if (lalign_b || ealign_b) wait_b = 1'b0;
            if (rd_en_b) begin
                if (wait_b) line_viol++;
                rd_b++;
                lr_b++;
                if (lr_b == cur_hact) begin
                    lr_b   = 0;
                    wait_b = 1'b1;
                end
            end
            if (tvalid_b && axi_tready) begin
                qb.push_back('{tdata_b, tkeep_b, tuser_b, tlast_b});
                hs_cyc_b = cyc;
                if (tlast_b) tl_hs_b++;
            end
            if (falign_b)   begin fal_b++; fal_cyc_b = cyc; end
            if (lalign_b)   lal_b++;
            if (ealign_b)   begin eal_b++; eal_cyc_b = cyc; end
            if (sync_err_b) se_b++;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // One full frame with tready=1 and a never-empty FIFO, on instance A (sel 0) or B (sel 1)
    task automatic run_frame(input int sel, input int hact, input int vact);
        int f0, e0, r0, t0;
        hactive = 16'(hact); vactive = 16'(vact); cur_hact = hact;
        axi_tready = 1'b1; fifo_empty = 1'b0;
        rd_mark = rd_total;
        if (sel == 0) begin
            f0 = fal_a; e0 = eal_a;
            en_a = 1'b1; t0 = cyc;
            for (int t = 0; t < 20 && fal_a == f0; t++) tick();
            en_a = 1'b0;
            check("a_falign_count", 64'(fal_a), 64'(f0 + 1));
            check("a_falign_latency", 64'(fal_cyc_a), 64'(t0 + 1));
            for (int t = 0; t < 400 && eal_a == e0; t++) tick();
            check("a_ealign_count", 64'(eal_a), 64'(e0 + 1));
            check("a_ealign_after_last", 64'(eal_cyc_a), 64'(hs_cyc_a + 1));
        end else begin
            f0 = fal_b; e0 = eal_b; r0 = rd_b;
            en_b = 1'b1;
            repeat (5) tick();
            check("b_no_read_before_vsync", 64'(rd_b), 64'(r0));
            check("b_no_falign_before_vsync", 64'(fal_b), 64'(f0));
            in_vsync = 1'b1; t0 = cyc;
            tick();
            in_vsync = 1'b0; en_b = 1'b0;
            tick();
            check("b_falign_count", 64'(fal_b), 64'(f0 + 1));
            check("b_falign_latency", 64'(fal_cyc_b), 64'(t0 + 1));
            for (int t = 0; t < 400 && eal_b == e0; t++) tick();
            check("b_ealign_count", 64'(eal_b), 64'(e0 + 1));
            check("b_ealign_after_last", 64'(eal_cyc_b), 64'(hs_cyc_b + 1));
        end
    endtask

    typedef struct {
        int          sel;
        int          hact;
        int          vact;
        int          nbeats;
        int          idx;
        logic [47:0] dat;
        logic [1:0]  keep;
        logic        user;
        logic        last;
    } vec_t;
    vec_t vecs[11];

    initial begin
        int   base, f0, e0, l0, s0, stalls, tl0, nb, errs;
        cap_t got;
        logic [47:0] exp_w;

        // PPC=1, 4x2 frame: pixels 1..8, tuser on beat 0, tlast on beats 3 and 7
        for (int i = 0; i < 8; i++)
            vecs[i] = '{0, 4, 2, 8, i, 48'(i + 1), 2'b01, (i == 0), (i == 3 || i == 7)};
        // PPC=2, 5x1 frame: last beat half empty, zero-filled
        vecs[8]  = '{1, 5, 1, 3, 0, 48'h000002_000001, 2'b11, 1'b1, 1'b0};
        vecs[9]  = '{1, 5, 1, 3, 1, 48'h000004_000003, 2'b11, 1'b0, 1'b0};
        vecs[10] = '{1, 5, 1, 3, 2, 48'h000000_000005, 2'b01, 1'b0, 1'b1};

        aresetn = 1'b0; en_a = 1'b0; en_b = 1'b0; in_vsync = 1'b0;
        fifo_empty = 1'b0; axi_tready = 1'b1; hactive = 16'd4; vactive = 16'd2;
        tick();
        check("rst_tvalid_a", 64'(tvalid_a), 64'd0);
        check("rst_rd_en_a", 64'(rd_en_a), 64'd0);
        check("rst_tdata_a", 64'(tdata_a), 64'd0);
        check("rst_falign_a", 64'(falign_a), 64'd0);
        check("rst_tvalid_b", 64'(tvalid_b), 64'd0);
        check("rst_pulses_b", 64'({falign_b, lalign_b, ealign_b, sync_err_b, tuser_b, tlast_b}), 64'd0);
        tick();
        aresetn = 1'b1;
        tick();

        base = 0;
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].idx == 0) begin
                base = (vecs[i].sel == 0) ? qa.size() : qb.size();
                run_frame(vecs[i].sel, vecs[i].hact, vecs[i].vact);
                nb = ((vecs[i].sel == 0) ? qa.size() : qb.size()) - base;
                check("vec_beat_count", 64'(nb), 64'(vecs[i].nbeats));
            end
            got = (vecs[i].sel == 0) ? qa[base + vecs[i].idx] : qb[base + vecs[i].idx];
            check($sformatf("vec%0d_tdata", i), 64'(got.dat), 64'(vecs[i].dat));
            check($sformatf("vec%0d_tkeep", i), 64'(got.keep), 64'(vecs[i].keep));
            check($sformatf("vec%0d_tuser", i), 64'(got.user), 64'(vecs[i].user));
            check($sformatf("vec%0d_tlast", i), 64'(got.last), 64'(vecs[i].last));
        end

        // LINE mode 3x3 on B, sink stalls 5 cycles at every tlast
        hactive = 16'd3; vactive = 16'd3; cur_hact = 3; rd_mark = rd_total;
        axi_tready = 1'b1; fifo_empty = 1'b0;
        l0 = lal_b; e0 = eal_b; base = qb.size(); stalls = 0; tl0 = tl_hs_b;
        en_b = 1'b1; in_vsync = 1'b1;
        tick();
        in_vsync = 1'b0; en_b = 1'b0;
        for (int t = 0; t < 300 && eal_b == e0; t++) begin
            if (tvalid_b && tlast_b && stalls == tl_hs_b - tl0) begin
                axi_tready = 1'b0;
                repeat (5) tick();
                axi_tready = 1'b1;
                stalls++;
            end
            tick();
        end
        check("line_lalign_count", 64'(lal_b - l0), 64'd2);
        check("line_ealign_count", 64'(eal_b - e0), 64'd1);
        check("line_beat_count", 64'(qb.size() - base), 64'd6);
        check("line_stalls", 64'(stalls), 64'd3);
        check("line_last_beat", 64'({qb[base + 5].dat, qb[base + 5].keep, qb[base + 5].last}),
              64'({48'h000000_000009, 2'b01, 1'b1}));
        check("line_no_read_while_waiting", 64'(line_viol), 64'd0);

        // Second vsync rise mid-frame on B: one sync_err, frame otherwise unchanged
        hactive = 16'd4; vactive = 16'd2; cur_hact = 4; rd_mark = rd_total;
        f0 = fal_b; e0 = eal_b; s0 = se_b; base = qb.size();
        en_b = 1'b1; in_vsync = 1'b1;
        tick();
        en_b = 1'b0; in_vsync = 1'b0;
        tick();
        in_vsync = 1'b1;
        tick();
        in_vsync = 1'b0;
        for (int t = 0; t < 300 && eal_b == e0; t++) tick();
        check("sync_err_count", 64'(se_b - s0), 64'd1);
        check("sync_beat_count", 64'(qb.size() - base), 64'd4);
        check("sync_single_falign", 64'(fal_b - f0), 64'd1);
        check("sync_ealign", 64'(eal_b - e0), 64'd1);

        // hactive=0 never starts a frame
        hactive = 16'd0; vactive = 16'd2;
        f0 = fal_a; s0 = rd_a; base = qa.size();
        en_a = 1'b1;
        repeat (20) tick();
        en_a = 1'b0;
        check("zero_h_no_falign", 64'(fal_a), 64'(f0));
        check("zero_h_no_read", 64'(rd_a), 64'(s0));
        check("zero_h_no_beat", 64'(qa.size()), 64'(base));

        // Three 16x4 frames on A with random tready and random FIFO empties
        hactive = 16'd16; vactive = 16'd4; rd_mark = rd_total;
        f0 = fal_a; e0 = eal_a; base = qa.size();
        for (int t = 0; t < 6000 && eal_a < e0 + 3; t++) begin
            en_a       = (fal_a < f0 + 3);
            axi_tready = 1'($urandom_range(0, 1));
            fifo_empty = ($urandom_range(0, 3) == 0);
            tick();
        end
        en_a = 1'b0; axi_tready = 1'b1; fifo_empty = 1'b0;
        tick();
        check("rand_frames", 64'(eal_a - e0), 64'd3);
        check("rand_beat_count", 64'(qa.size() - base), 64'd192);
        errs = 0;
        for (int j = 0; j < 192; j++) begin
            exp_w = 48'(j + 1);
            got = qa[base + j];
            if ({got.dat, got.user, got.last} !== {exp_w, (j % 64 == 0), (j % 16 == 15)}) begin
                if (errs < 8)
                    $display("FAIL rand_beat%0d: got dat=%0d user=%0b last=%0b, expected dat=%0d user=%0b last=%0b",
                             j, got.dat, got.user, got.last, exp_w, (j % 64 == 0), (j % 16 == 15));
                errs++;
            end
        end
        check("rand_scoreboard_errors", 64'(errs), 64'd0);
        check("rand_stall_stability", 64'(stall_viol), 64'd0);
        check("rand_no_read_when_full", 64'(occ_viol), 64'd0);
        check("once_no_lalign", 64'(lal_a), 64'd0);
        check("a_no_sync_err", 64'(se_a), 64'd0);

        // Reset mid-frame with a full output buffer, then a clean frame
        hactive = 16'd16; vactive = 16'd4; rd_mark = rd_total;
        axi_tready = 1'b0; fifo_empty = 1'b0;
        en_a = 1'b1;
        repeat (6) tick();
        en_a = 1'b0;
        check("pre_reset_tvalid", 64'(tvalid_a), 64'd1);
        check("pre_reset_rd_blocked", 64'(rd_en_a), 64'd0);
        aresetn = 1'b0;
        #1;
        check("reset_tvalid_now", 64'(tvalid_a), 64'd0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        check("post_reset_idle_tvalid", 64'(tvalid_a), 64'd0);
        base = qa.size();
        run_frame(0, 16, 4);
        check("post_reset_beats", 64'(qa.size() - base), 64'd64);
        check("post_reset_first_tuser", 64'(qa[base].user), 64'd1);
        check("post_reset_first_data", 64'(qa[base].dat), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_video_out_port.md
# axis_video_out_port

Packs pixels from a show-ahead pixel FIFO into AXI4-Stream video beats of PPC pixels each. Generates tuser (start of frame), tlast (end of line) and tkeep, and absorbs sink backpressure in a 2-entry output buffer. It sits between the VDMA read-side line FIFO and the video sink. In LINE mode it paces the upstream fetch one line at a time, and it optionally aligns each frame start to an external vsync.

## Interface
- DSIZE, 24: bits per pixel
- PPC, 1: pixels per beat, 1..4; tdata width DSIZE*PPC
- MODE, "ONCE": "ONCE" reads a whole frame continuously; "LINE" stops after each line until that line's tlast is accepted
- FRAME_SYNC, "OFF": "ON" starts each frame on an in_vsync rising edge; "OFF" starts as soon as enabled
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- enable  in  1  allows a new frame to start; sampled only in IDLE
- hactive  in  16  pixels per line, latched at frame start
- vactive  in  16  lines per frame, latched at frame start
- in_vsync  in  1  synchronous to aclk
- in_data  in  DSIZE  FIFO head pixel
- fifo_empty  in  1  FIFO empty flag
- rd_en  out  1  FIFO pop
- axi_tdata  out  DSIZE*PPC  pixel k occupies bits [k*DSIZE +: DSIZE]; pixel 0 is the earliest
- axi_tkeep  out  PPC  one bit per valid pixel
- axi_tvalid, axi_tuser, axi_tlast  out  1 each  AXI4-Stream sideband
- axi_tready  in  1  sink ready
- falign  out  1  pulse on frame start
- lalign  out  1  pulse on line done (LINE mode only; stuck 0 in ONCE)
- ealign  out  1  pulse on frame done
- sync_err  out  1  pulse on in_vsync rise during a frame (FRAME_SYNC "ON" only)

## Operation
- State machine states: IDLE, RUN, LWAIT, DRAIN.
- IDLE -> RUN when both hold:
  - enable=1 and hactive!=0 and vactive!=0;
  - FRAME_SYNC="OFF", or vs_rise=1 (vs_rise = in_vsync & ~vs_q, where vs_q is in_vsync registered).
- On the IDLE -> RUN transition: latch hactive/vactive, clear pcnt (pixel in line, 16b) and lcnt (line, 16b), and register falign=1 for the first RUN cycle.
- rd_en = (state==RUN) & ~fifo_empty & (obuf_cnt<2). rd_en has no combinational path from axi_tready.
- Each read pixel goes into packer slot pcnt mod PPC, then pcnt increments.
- A beat is complete on either condition:
  - the slot index reaches PPC-1;
  - pcnt == hactive-1 (end of line).
- On the end-of-line condition, any unfilled slots are filled with 0 and their tkeep bits are 0.
- A completed beat, including the pixel read in the same cycle, is pushed into obuf on that clock edge.
- tuser=1 only on the first beat of the frame. tlast=1 on the final beat of every line.
- End of line (pcnt wraps to 0, lcnt increments):
  - last line: RUN -> DRAIN;
  - otherwise, LINE mode: RUN -> LWAIT;
  - otherwise, ONCE mode: stay in RUN.
- LWAIT: when the tlast beat is handshaken, pulse lalign and return to RUN in the next cycle.
- DRAIN: when the final tlast beat is handshaken, pulse ealign and go to IDLE. A new frame can start one cycle later.
- obuf is a 2-entry FIFO with push and pop in the same cycle allowed. A pop is tvalid&tready. obuf_cnt stays within 0..2.
- A vs_rise in RUN, LWAIT or DRAIN with FRAME_SYNC="ON" pulses sync_err. The current frame continues unchanged.
- enable deasserted mid-frame: the frame completes normally.
- lcnt/pcnt compare against the latched sizes. Changes on hactive/vactive mid-frame are ignored.

## Timing
- Reset values: all outputs 0; state IDLE; obuf empty; counters 0; vs_q 0.
- Reset mid-frame clears everything immediately. No beats are emitted until the next frame start.
- Start latency:
  - FRAME_SYNC="ON": in_vsync rises in cycle N -> falign and the first possible rd_en in cycle N+1;
  - FRAME_SYNC="OFF": enable high in IDLE in cycle N -> falign in cycle N+1.
- Beat latency: rd_en of the pixel that completes a beat in cycle N -> axi_tvalid high in cycle N+1.
- AXI rule: while tvalid=1 and tready=0, tdata, tkeep, tuser and tlast are held stable and tvalid does not drop.
- Throughput: with tready=1, one pixel per cycle is read and one beat per PPC cycles is sent. PPC=1 sustains 1 beat/cycle.
- All align, err and pulse outputs are registered and exactly one cycle wide.

## Test plan
- PPC=1, hactive=4, vactive=2, tready=1, FIFO always full:
  - 8 beats;
  - tuser on beat 0 only; tlast on beats 3 and 7;
  - falign once; ealign one cycle after beat 7 is handshaken.
- PPC=2, hactive=5, vactive=1, pixels 1..5:
  - 3 beats: {2,1} keep 11; {4,3} keep 11; {0,5} keep 01, with tlast on this beat.
- Random tready (50%) with random fifo_empty, 3 frames at 16x4:
  - scoreboard matches every pixel in order;
  - payload is stable under stall;
  - rd_en never asserted while obuf_cnt==2.
- MODE="LINE", hactive=3, vactive=3, tready held low 5 cycles at each line end:
  - no rd_en between a line's last read and its lalign;
  - exactly 2 lalign pulses, then 1 ealign.
- FRAME_SYNC="ON":
  - no rd_en until in_vsync rises;
  - a second vsync mid-frame -> one sync_err pulse, and the beat count still equals hactive*vactive/PPC.
- Boundary cases:
  - hactive=0 with enable=1 -> stays IDLE, no rd_en;
  - aresetn pulsed low mid-frame -> tvalid=0 immediately, and the next frame begins with tuser=1.
